// File: rtl/div_ctrl.sv
// Iterative restoring divide sequencer for DIV/DIVU: one quotient bit per cycle.
// Optional build macro DIV_EARLY_EXIT_EN finishes immediately when |dividend| < |divisor|.
module div_ctrl #(
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic                  annul_i,
  input  logic                  signed_i,
  input  logic [DATA_W-1:0]     oprd1_i,
  input  logic [DATA_W-1:0]     oprd2_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o,
  output logic                  stall_o
);

  // state  | meaning
  // IDLE   | waiting for start_i
  // BYZERO | divisor was zero, result forced to 0
  // BUSY   | shifting and subtracting, one bit per cycle
  // DONE   | result valid, held until start_i drops
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BYZERO = 2'd1,
    BUSY   = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W);

  state_t            state;
  logic [CNT_W-1:0]  counter;
  logic [DATA_W-1:0] dvs_mag;
  logic [DATA_W-1:0] rem;
  logic [DATA_W-1:0] quot;
  logic              neg_quot;
  logic              neg_rem;

  logic [DATA_W-1:0] mag1;
  logic [DATA_W-1:0] mag2;
  logic [DATA_W:0]   rem_sh;
  logic [DATA_W:0]   trial;
  logic [DATA_W-1:0] fix_quot;
  logic [DATA_W-1:0] fix_rem;
  logic              early_exit;
  logic              go;

  assign go   = start_i && !annul_i;
  assign mag1 = (signed_i && oprd1_i[DATA_W-1]) ? -oprd1_i : oprd1_i;
  assign mag2 = (signed_i && oprd2_i[DATA_W-1]) ? -oprd2_i : oprd2_i;

`ifdef DIV_EARLY_EXIT_EN
  assign early_exit = (mag1 < mag2);
`else
  assign early_exit = 1'b0;
`endif

  // quot doubles as the dividend shift register; its MSB feeds the remainder
  assign rem_sh   = {rem, quot[DATA_W-1]};
  assign trial    = rem_sh - {1'b0, dvs_mag};
  assign fix_quot = neg_quot ? -quot : quot;
  assign fix_rem  = neg_rem ? -rem : rem;

  assign stall_o  = go && (state != DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      counter  <= '0;
      dvs_mag  <= '0;
      rem      <= '0;
      quot     <= '0;
      neg_quot <= 1'b0;
      neg_rem  <= 1'b0;
      result_o <= '0;
      ready_o  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          ready_o  <= 1'b0;
          result_o <= '0;
          if (go) begin
            if (oprd2_i == '0) begin
              state <= BYZERO;
            end else if (early_exit) begin
              state    <= DONE;
              ready_o  <= 1'b1;
              result_o <= {oprd1_i, {DATA_W{1'b0}}};
            end else begin
              state    <= BUSY;
              quot     <= mag1;
              dvs_mag  <= mag2;
              rem      <= '0;
              counter  <= '0;
              neg_quot <= signed_i && (oprd1_i[DATA_W-1] ^ oprd2_i[DATA_W-1]);
              neg_rem  <= signed_i && oprd1_i[DATA_W-1];
            end
          end
        end

        BYZERO: begin
          if (annul_i) begin
            state <= IDLE;
          end else begin
            state    <= DONE;
            ready_o  <= 1'b1;
            result_o <= '0;
          end
        end

        BUSY: begin
          if (annul_i) begin
            state <= IDLE;
          end else if (counter == LAST_CNT) begin
            state    <= DONE;
            ready_o  <= 1'b1;
            result_o <= {fix_rem, fix_quot};
          end else begin
            counter <= counter + 1'b1;
            if (!trial[DATA_W]) begin
              rem  <= trial[DATA_W-1:0];
              quot <= {quot[DATA_W-2:0], 1'b1};
            end else begin
              rem  <= rem_sh[DATA_W-1:0];
              quot <= {quot[DATA_W-2:0], 1'b0};
            end
          end
        end

        DONE: begin
          if (annul_i || !start_i) begin
            state    <= IDLE;
            ready_o  <= 1'b0;
            result_o <= '0;
          end
        end

        default: begin
          state    <= IDLE;
          ready_o  <= 1'b0;
          result_o <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_ctrl.sv
// Randomized bench for div_ctrl against an arithmetic reference model.
// Honours DIV_EARLY_EXIT_EN for the expected latency.
module tb_div_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_i = 1'b0;
  logic        annul_i = 1'b0;
  logic        signed_i = 1'b0;
  logic [31:0] oprd1_i = '0;
  logic [31:0] oprd2_i = '0;
  logic [63:0] result_o;
  logic        ready_o;
  logic        stall_o;

  int n_cmp = 0;
  int n_err = 0;

  div_ctrl #(.DATA_W(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .start_i  (start_i),
    .annul_i  (annul_i),
    .signed_i (signed_i),
    .oprd1_i  (oprd1_i),
    .oprd2_i  (oprd2_i),
    .result_o (result_o),
    .ready_o  (ready_o),
    .stall_o  (stall_o)
  );

  always #5 clk = ~clk;

  function automatic longint mag(input logic [31:0] v, input logic s);
    longint x;
    x = s ? longint'($signed(v)) : longint'({32'h0, v});
    return (x < 0) ? -x : x;
  endfunction

  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                          input logic s);
    longint x, y, q, r;
    if (b == 32'h0) return 64'h0;
    x = s ? longint'($signed(a)) : longint'({32'h0, a});
    y = s ? longint'($signed(b)) : longint'({32'h0, b});
    q = x / y;
    r = x % y;
    return {r[31:0], q[31:0]};
  endfunction

  // edges after the start edge until ready_o is visible
  function automatic int ref_lat(input logic [31:0] a, input logic [31:0] b, input logic s);
    if (b == 32'h0) return 1;
`ifdef DIV_EARLY_EXIT_EN
    if (mag(a, s) < mag(b, s)) return 0;
`endif
    return 33;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // behavioural model: tracks the in-flight op by counting edges with start held
  logic        m_init = 1'b0;
  logic        m_active = 1'b0;
  int          m_edges = 0;
  int          m_lat = 0;
  logic [63:0] m_res = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_init   = 1'b1;
      m_active = 1'b0;
    end else if (m_active) begin
      if (annul_i || !start_i) m_active = 1'b0;
      else m_edges++;
    end else if (start_i && !annul_i) begin
      m_active = 1'b1;
      m_edges  = 1;
      m_res    = ref_div(oprd1_i, oprd2_i, signed_i);
      m_lat    = ref_lat(oprd1_i, oprd2_i, signed_i);
    end
  end

  always @(negedge clk) begin
    logic exp_rdy;
    if (m_init) begin
      exp_rdy = m_active && (m_edges >= m_lat + 1);
      chk("ready_o", {63'h0, ready_o}, {63'h0, exp_rdy});
      chk("result_o", result_o, exp_rdy ? m_res : 64'h0);
      chk("stall_o", {63'h0, stall_o}, {63'h0, start_i && !annul_i && !exp_rdy});
    end
  end

  task automatic scramble_step();
    @(posedge clk);
    #1;
    oprd1_i = $urandom;
    oprd2_i = $urandom;
  endtask

  // entered and left at #1 after a posedge
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                        input int annul_at, input int rst_at,
                        input logic use_lit, input logic [63:0] lit, input string nm);
    int lat;
    lat      = ref_lat(a, b, s);
    oprd1_i  = a;
    oprd2_i  = b;
    signed_i = s;
    start_i  = 1'b1;
    if (annul_at > 0) begin
      repeat (annul_at) scramble_step();
      annul_i = 1'b1;
      @(posedge clk);
      #1;
      annul_i = 1'b0;
      start_i = 1'b0;
    end else if (rst_at > 0) begin
      repeat (rst_at) scramble_step();
      rst     = 1'b1;
      start_i = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
    end else begin
      repeat (lat + 2) scramble_step();
      if (use_lit) chk(nm, result_o, lit);
      start_i = 1'b0;
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    logic [31:0] a, b;
    logic        s;
    int          lat, an, rs, mode;

    chk("model_divu_100_7", ref_div(32'd100, 32'd7, 1'b0), 64'h00000002_0000000E);
    chk("model_div_m7_2", ref_div(32'hFFFFFFF9, 32'd2, 1'b1), 64'hFFFFFFFF_FFFFFFFD);
    chk("model_div_7_m2", ref_div(32'd7, 32'hFFFFFFFE, 1'b1), 64'h00000001_FFFFFFFD);
    chk("model_ovf", ref_div(32'h80000000, 32'hFFFFFFFF, 1'b1), 64'h00000000_80000000);
    chk("model_lat_byzero", 64'(ref_lat(32'd5, 32'd0, 1'b0)), 64'd1);

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    run_op(32'd100, 32'd7, 1'b0, 0, 0, 1'b1, 64'h00000002_0000000E, "divu_100_7");
    run_op(32'hFFFFFFF9, 32'd2, 1'b1, 0, 0, 1'b1, 64'hFFFFFFFF_FFFFFFFD, "div_m7_2");
    run_op(32'd7, 32'hFFFFFFFE, 1'b1, 0, 0, 1'b1, 64'h00000001_FFFFFFFD, "div_7_m2");
    run_op(32'd5, 32'd0, 1'b0, 0, 0, 1'b1, 64'h0, "divu_5_0");
    run_op(32'd100, 32'd7, 1'b0, 10, 0, 1'b0, 64'h0, "annul");
    run_op(32'd9, 32'd3, 1'b0, 0, 0, 1'b1, 64'h00000000_00000003, "divu_9_3");
    run_op(32'd100, 32'd7, 1'b0, 0, 15, 1'b0, 64'h0, "rst_mid");
    run_op(32'h80000000, 32'hFFFFFFFF, 1'b1, 0, 0, 1'b1, 64'h00000000_80000000, "div_ovf");
    run_op(32'd3, 32'd10, 1'b0, 0, 0, 1'b1, 64'h00000003_00000000, "divu_3_10");
    run_op(32'hFFFFFFFD, 32'd10, 1'b1, 0, 0, 1'b1, 64'hFFFFFFFD_00000000, "div_m3_10");

    for (int i = 0; i < 30; i++) begin
      s    = 1'($urandom_range(0, 1));
      mode = $urandom_range(0, 5);
      a    = (mode < 2) ? 32'($urandom_range(0, 300)) : $urandom;
      if (mode == 0) a = -a;
      case ($urandom_range(0, 6))
        0:       b = 32'h0;
        1:       b = 32'hFFFFFFFF;
        2, 3:    b = 32'($urandom_range(1, 50));
        default: b = $urandom;
      endcase
      lat = ref_lat(a, b, s);
      an  = ($urandom_range(0, 5) == 0) ? $urandom_range(1, lat + 1) : 0;
      rs  = (an == 0 && $urandom_range(0, 9) == 0) ? $urandom_range(1, lat + 1) : 0;
      run_op(a, b, s, an, rs, 1'b0, 64'h0, "rand");
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end

    repeat (2) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
